exp_normalize_block: RTL and testbench

EXP_NORMALIZE_BLOCK -- requirements
Module: exp_normalize_block

---
 rtl/softmax_pkg.sv | 22 ++
 rtl/fxp_divider.sv | 78 +++++++
 rtl/exp_normalize_block.sv | 102 ++++++++++
 tb/tb_exp_normalize_block.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared softmax definitions: default sizing, normalize-stage FSM encoding,
// and the accumulator width helper.
package softmax_pkg;

  localparam int DATA_SIZE_DEF      = 32;
  localparam int NUMBER_OF_DATA_DEF = 10;
  localparam int FRAC_BITS_DEF      = 16;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    LOAD    = 3'd1,
    DIVIDE  = 3'd2,
    EMIT    = 3'd3,
    DONE    = 3'd4
  } norm_state_e;

  // A sum of n words of data_w bits fits in data_w + clog2(n) bits.
  function automatic int sum_width(input int data_w, input int n);
    return data_w + $clog2(n);
  endfunction

endpackage

// File: rtl/fxp_divider.sv
// Restoring divider, one quotient bit per cycle, QUOTIENT_W cycles per result.
// Caller guarantees dividend >> QUOTIENT_W < divisor; a zero divisor yields 0.
module fxp_divider #(
  parameter int DIVIDEND_W = 48,
  parameter int DIVISOR_W  = 36,
  parameter int QUOTIENT_W = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [QUOTIENT_W-1:0] quotient_o
);

  localparam int CNT_W = $clog2(QUOTIENT_W);

  logic [DIVISOR_W-1:0]  rem_q, divisor_q, src_rem, src_div, rem_n;
  logic [QUOTIENT_W-1:0] quo_q, src_quo, quo_n;
  logic [DIVISOR_W:0]    shifted;
  logic                  qbit;
  logic [CNT_W-1:0]      cnt_q;
  logic                  busy_q, done_q;

  // The start edge performs the first iteration directly on the new operands,
  // so the result is complete after exactly QUOTIENT_W edges.
  always_comb begin
    // NOTE: every combinational signal gets a default first so no path infers a latch.
    src_rem = rem_q;
    src_quo = quo_q;
    src_div = divisor_q;
    if (start_i) begin
      src_rem = DIVISOR_W'(dividend_i >> QUOTIENT_W);
      src_quo = dividend_i[QUOTIENT_W-1:0];
      src_div = divisor_i;
    end
    shifted = {src_rem, src_quo[QUOTIENT_W-1]};
    qbit    = (src_div != '0) && (shifted >= {1'b0, src_div});
    rem_n   = qbit ? DIVISOR_W'(shifted - {1'b0, src_div}) : shifted[DIVISOR_W-1:0];
    quo_n   = {src_quo[QUOTIENT_W-2:0], qbit};
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done_q <= 1'b0;
      if (start_i) begin
        rem_q     <= rem_n;
        quo_q     <= quo_n;
        divisor_q <= divisor_i;
        cnt_q     <= CNT_W'(QUOTIENT_W - 1);
        busy_q    <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/exp_normalize_block.sv
// Softmax normalize stage: buffers N exp values, sums them, then emits each
// value divided by the sum, one result every data_size+2 cycles.
module exp_normalize_block
  import softmax_pkg::*;
#(
  parameter int data_size      = DATA_SIZE_DEF,
  parameter int number_of_data = NUMBER_OF_DATA_DEF,
  parameter int frac_bits      = FRAC_BITS_DEF
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic [data_size-1:0] exp_data_i,
  input  logic                 exp_data_valid_i,
  output logic [data_size-1:0] norm_data_o,
  output logic                 norm_data_valid_o,
  output logic                 norm_done_o
);

  localparam int SUM_W = sum_width(data_size, number_of_data);
  localparam int IDX_W = $clog2(number_of_data);
  localparam int DVD_W = data_size + frac_bits;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(number_of_data - 1);

  norm_state_e          state_q;
  logic [data_size-1:0] buf_q [number_of_data];
  logic [SUM_W-1:0]     sum_q;
  logic [IDX_W-1:0]     in_cnt_q, out_cnt_q;
  logic [data_size-1:0] norm_data_q;
  logic                 norm_valid_q, norm_done_q;

  logic                 div_start, div_busy, div_done;
  logic [DVD_W-1:0]     div_dividend;
  logic [data_size-1:0] div_quotient;

  assign div_start    = (state_q == LOAD) && !div_busy;
  assign div_dividend = {buf_q[out_cnt_q], {frac_bits{1'b0}}};

  fxp_divider #(
    .DIVIDEND_W(DVD_W),
    .DIVISOR_W (SUM_W),
    .QUOTIENT_W(data_size)
  ) u_div (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .start_i   (div_start),
    .dividend_i(div_dividend),
    .divisor_i (sum_q),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quotient_o(div_quotient)
  );

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= COLLECT;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      sum_q        <= '0;
      norm_data_q  <= '0;
      norm_valid_q <= 1'b0;
      norm_done_q  <= 1'b0;
      // NOTE: the buffer is cleared too, so nothing from an aborted pass survives reset.
      for (int i = 0; i < number_of_data; i++) buf_q[i] <= '0;
    end else begin
      norm_valid_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (exp_data_valid_i) begin
            buf_q[in_cnt_q] <= exp_data_i;
            sum_q           <= sum_q + SUM_W'(exp_data_i);
            if (in_cnt_q == LAST_IDX) begin
              state_q   <= LOAD;
              out_cnt_q <= '0;
            end else begin
              in_cnt_q <= in_cnt_q + 1'b1;
            end
          end
        end
        LOAD:   if (div_start) state_q <= DIVIDE;
        DIVIDE: if (div_done)  state_q <= EMIT;
        EMIT: begin
          norm_data_q  <= div_quotient;
          norm_valid_q <= 1'b1;
          if (out_cnt_q < LAST_IDX) begin
            out_cnt_q <= out_cnt_q + 1'b1;
            state_q   <= LOAD;
          end else begin
            norm_done_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE:    state_q <= DONE;
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign norm_data_o       = norm_data_q;
  assign norm_data_valid_o = norm_valid_q;
  assign norm_done_o       = norm_done_q;

endmodule

// File: tb/tb_exp_normalize_block.sv
// Scoreboard bench for exp_normalize_block: expected results and their arrival
// cycles come from plain-arithmetic softmax normalization.
module tb_exp_normalize_block;

  localparam int DS     = 32;
  localparam int N      = 10;
  localparam int FB     = 16;
  localparam int PERIOD = DS + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_i = 1'b0;
  logic [DS-1:0] data_i = '0;
  logic [DS-1:0] norm_data;
  logic          norm_valid, norm_done;

  exp_normalize_block #(
    .data_size     (DS),
    .number_of_data(N),
    .frac_bits     (FB)
  ) dut (
    .clock_i          (clk),
    .reset_n_i        (rst_n),
    .exp_data_i       (data_i),
    .exp_data_valid_i (valid_i),
    .norm_data_o      (norm_data),
    .norm_data_valid_o(norm_valid),
    .norm_done_o      (norm_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DS-1:0] value;
    int            cyc;
    int            idx;
  } exp_t;

  exp_t          exp_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  logic [DS-1:0] stim [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [DS-1:0] ref_norm(input longint unsigned x, input longint unsigned s);
    if (s == 0) return '0;
    return DS'((x << FB) / s);
  endfunction

  // Monitor: pops one expected entry per output pulse.
  int            pulses_seen = 0;
  bit            have_last = 0;
  logic [DS-1:0] last_val = '0;
  logic [DS-1:0] prev_val = '0;
  exp_t          got;

  always @(negedge clk) begin
    if (!rst_n) begin
      pulses_seen = 0;
      have_last   = 0;
    end else begin
      if (norm_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: got data 0x%0h, required no pulse (cycle %0d)", norm_data, cyc);
        end else begin
          got = exp_q.pop_front();
          check($sformatf("norm_data[%0d]", got.idx), norm_data, got.value);
          check($sformatf("pulse_cycle[%0d]", got.idx), cyc, got.cyc);
          if (have_last) check("hold_between_pulses", prev_val, last_val);
          if (got.idx < N - 1) check("done_early", norm_done, 0);
        end
        last_val  = norm_data;
        have_last = 1;
        pulses_seen++;
      end
      prev_val = norm_data;
    end
  end

  task automatic run_pass(input bit gaps, input int extras, input bit wait_done);
    longint unsigned sum = 0;
    int t_acc = 0;
    exp_t e;
    for (int i = 0; i < N; i++) sum += stim[i];
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        repeat (g) begin
          valid_i = 1'b0;
          data_i  = $urandom;
          @(posedge clk); #1;
        end
      end
      valid_i = 1'b1;
      data_i  = stim[i];
      if (i == N - 1) t_acc = cyc + 1;
      @(posedge clk); #1;
    end
    for (int j = 0; j < N; j++) begin
      e.value = ref_norm(stim[j], sum);
      e.cyc   = t_acc + PERIOD * (j + 1);
      e.idx   = j;
      exp_q.push_back(e);
    end
    repeat (extras) begin
      valid_i = 1'b1;
      data_i  = $urandom;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    if (wait_done) begin
      int budget;
      budget = PERIOD * (N + 2);
      while (exp_q.size() != 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() != 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pass_timeout: %0d results outstanding, required 0", exp_q.size());
        exp_q.delete();
      end
      repeat (2) @(negedge clk);
      check("done_sticky", norm_done, 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  norm_data,  0);
    check({tag, "_valid"}, norm_valid, 0);
    check({tag, "_done"},  norm_done,  0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) stim[i] = $urandom >> $urandom_range(0, 31);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DS-1:0] saved [N];
    int budget;

    repeat (3) @(negedge clk);
    check_reset_outputs("power_on");
    rst_n = 1'b1;

    // Uniform 1.0 inputs.
    for (int i = 0; i < N; i++) stim[i] = 32'h0001_0000;
    run_pass(0, 0, 1);

    // One-hot input.
    do_reset();
    for (int i = 0; i < N; i++) stim[i] = (i == 0) ? 32'h0001_0000 : 32'h0;
    run_pass(0, 0, 1);

    // All zero: divide-by-zero path.
    do_reset();
    for (int i = 0; i < N; i++) stim[i] = '0;
    run_pass(0, 0, 1);

    // Full-scale inputs: accumulator width.
    do_reset();
    for (int i = 0; i < N; i++) stim[i] = 32'hFFFF_FFFF;
    run_pass(0, 0, 1);

    // Gapped input with trailing extras, then the same vector gap-free.
    do_reset();
    fill_random();
    for (int i = 0; i < N; i++) saved[i] = stim[i];
    run_pass(1, 5, 1);
    do_reset();
    for (int i = 0; i < N; i++) stim[i] = saved[i];
    run_pass(0, 0, 1);

    // Reset during DIVIDE of result 3.
    do_reset();
    fill_random();
    run_pass(0, 0, 0);
    budget = PERIOD * (N + 2);
    while (pulses_seen < 3 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check("abort_reached_result3", pulses_seen, 3);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * PERIOD) @(negedge clk);
    check_reset_outputs("after_abort");
    fill_random();
    run_pass(0, 0, 1);

    // Random passes with random gaps and extras.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      fill_random();
      run_pass(1'($urandom_range(0, 1)), $urandom_range(0, 5), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
